// File: rtl/pe_filter_cache_pp.sv
// Per-PE ping-pong filter cache: one bank loads from the broadcast bus while the PE reads the other.
// Optional PE_FILTER_CACHE_PARITY_EN stores an even-parity bit per filter word and flags read errors.
module pe_filter_cache_pp #(
  parameter int unsigned PE_ID       = 0,
  parameter int unsigned PE_ID_WIDTH = 4,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned NUM_DOTS    = 4,
  parameter int unsigned ELEM_WIDTH  = 8,
  parameter int unsigned RAM_DEPTH   = 512,
  parameter int unsigned ADDR_WIDTH  = $clog2(RAM_DEPTH),
  parameter int unsigned FID_WIDTH   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                                        clock,
  input  logic                                        resetn,
  input  logic                                        i_wr_enable,
  input  logic [PE_ID_WIDTH-1:0]                      i_wr_pe_id,
  input  logic [FID_WIDTH-1:0]                        i_wr_filter_id,
  input  logic [ADDR_WIDTH-1:0]                       i_wr_addr,
  input  logic [NUM_DOTS*ELEM_WIDTH-1:0]              i_wr_data,
  input  logic                                        i_load_done,
  output logic                                        o_load_full,
  output logic [ADDR_WIDTH+FID_WIDTH:0]               o_write_count,
  output logic                                        o_overrun,
  input  logic                                        i_swap_req,
  output logic                                        o_swap_ack,
  output logic                                        o_read_bank,
  output logic                                        o_read_bank_ready,
  input  logic                                        i_read_enable,
  input  logic [ADDR_WIDTH-1:0]                       i_read_addr,
  output logic [NUM_DOTS*NUM_FILTERS*ELEM_WIDTH-1:0]  o_read_data,
  output logic                                        o_read_valid,
  output logic                                        o_parity_err
);

  localparam int unsigned WORD_WIDTH = NUM_DOTS * ELEM_WIDTH;
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + FID_WIDTH + 1;
  localparam int unsigned LANE_WIDTH = NUM_DOTS * NUM_FILTERS * ELEM_WIDTH;
`ifdef PE_FILTER_CACHE_PARITY_EN
  localparam int unsigned MEM_WIDTH  = WORD_WIDTH + 1;
`else
  localparam int unsigned MEM_WIDTH  = WORD_WIDTH;
`endif

  typedef enum logic [1:0] {
    LD_EMPTY   = 2'd0,
    LD_LOADING = 2'd1,
    LD_FULL    = 2'd2
  } load_state_e;

  load_state_e                load_state;
  logic                       rd_bank_sel;
  logic                       load_bank_c;
  logic                       wr_match_c;
  logic                       wr_land_c;
  logic                       swap_c;
  logic [MEM_WIDTH-1:0]       wr_word_c;

  logic [MEM_WIDTH-1:0]       mem [2][NUM_FILTERS][RAM_DEPTH];

  logic                       rd_valid_s1;
  logic                       rd_bank_s1;
  logic [ADDR_WIDTH-1:0]      rd_addr_s1;
  logic [MEM_WIDTH-1:0]       rd_word_c [NUM_FILTERS];
  logic [LANE_WIDTH-1:0]      rd_lanes_c;

  assign load_bank_c = ~o_read_bank;
  assign wr_match_c  = i_wr_enable && (i_wr_pe_id == PE_ID_WIDTH'(PE_ID))
                       && (32'(i_wr_filter_id) < NUM_FILTERS);
  assign wr_land_c   = wr_match_c && (load_state != LD_FULL);
  assign swap_c      = i_swap_req && (load_state == LD_FULL);

`ifdef PE_FILTER_CACHE_PARITY_EN
  assign wr_word_c = {^i_wr_data, i_wr_data};
`else
  assign wr_word_c = i_wr_data;
`endif

  // Load-bank FSM, write counter, swap handshake and bank pointer
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      load_state        <= LD_EMPTY;
      o_load_full       <= 1'b0;
      o_write_count     <= '0;
      o_overrun         <= 1'b0;
      o_swap_ack        <= 1'b0;
      o_read_bank       <= 1'b0;
      o_read_bank_ready <= 1'b0;
      rd_bank_sel       <= 1'b0;
    end else begin
      o_overrun   <= wr_match_c && (load_state == LD_FULL);
      o_swap_ack  <= swap_c;
      // Reads issued up to and including the ack cycle still see the old bank
      rd_bank_sel <= o_read_bank;
      if (swap_c) begin
        load_state        <= LD_EMPTY;
        o_load_full       <= 1'b0;
        o_write_count     <= '0;
        o_read_bank       <= ~o_read_bank;
        o_read_bank_ready <= 1'b1;
      end else begin
        if (wr_land_c && (o_write_count != '1)) begin
          o_write_count <= o_write_count + CNT_WIDTH'(1);
        end
        case (load_state)
          LD_EMPTY: begin
            if (i_load_done) begin
              load_state  <= LD_FULL;
              o_load_full <= 1'b1;
            end else if (wr_land_c) begin
              load_state  <= LD_LOADING;
            end
          end
          LD_LOADING: begin
            if (i_load_done) begin
              load_state  <= LD_FULL;
              o_load_full <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Filter storage, one write port into the load bank
  always_ff @(posedge clock) begin
    if (wr_land_c) begin
      mem[load_bank_c][i_wr_filter_id][i_wr_addr] <= wr_word_c;
    end
  end

  // Read stage 1: registered address and bank select
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_valid_s1 <= 1'b0;
      rd_bank_s1  <= 1'b0;
      rd_addr_s1  <= '0;
    end else begin
      rd_valid_s1 <= i_read_enable;
      if (i_read_enable) begin
        rd_bank_s1 <= rd_bank_sel;
        rd_addr_s1 <= i_read_addr;
      end
    end
  end

  // Gather every filter word and interleave dot-major
  always_comb begin
    rd_lanes_c = '0;
    for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
      rd_word_c[f] = mem[rd_bank_s1][FID_WIDTH'(f)][rd_addr_s1];
    end
    for (int unsigned d = 0; d < NUM_DOTS; d++) begin
      for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
        rd_lanes_c[(d*NUM_FILTERS+f)*ELEM_WIDTH +: ELEM_WIDTH] =
          rd_word_c[f][d*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
  end

  // Read stage 2: registered output, holds when idle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      o_read_valid <= 1'b0;
      o_read_data  <= '0;
    end else begin
      o_read_valid <= rd_valid_s1;
      if (rd_valid_s1) begin
        o_read_data <= rd_lanes_c;
      end
    end
  end

`ifdef PE_FILTER_CACHE_PARITY_EN
  logic par_err_c;

  always_comb begin
    par_err_c = 1'b0;
    for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
      par_err_c = par_err_c | (^rd_word_c[f]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      o_parity_err <= 1'b0;
    end else begin
      o_parity_err <= rd_valid_s1 && par_err_c;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_filter_cache_pp.sv
// Directed self-checking bench for pe_filter_cache_pp (default parameters).
module tb_pe_filter_cache_pp;

  logic          clock;
  logic          resetn;
  logic          i_wr_enable;
  logic [3:0]    i_wr_pe_id;
  logic [1:0]    i_wr_filter_id;
  logic [8:0]    i_wr_addr;
  logic [31:0]   i_wr_data;
  logic          i_load_done;
  logic          o_load_full;
  logic [11:0]   o_write_count;
  logic          o_overrun;
  logic          i_swap_req;
  logic          o_swap_ack;
  logic          o_read_bank;
  logic          o_read_bank_ready;
  logic          i_read_enable;
  logic [8:0]    i_read_addr;
  logic [127:0]  o_read_data;
  logic          o_read_valid;
  logic          o_parity_err;

  int n_checks = 0;
  int n_errors = 0;

  pe_filter_cache_pp dut (
    .clock             (clock),
    .resetn            (resetn),
    .i_wr_enable       (i_wr_enable),
    .i_wr_pe_id        (i_wr_pe_id),
    .i_wr_filter_id    (i_wr_filter_id),
    .i_wr_addr         (i_wr_addr),
    .i_wr_data         (i_wr_data),
    .i_load_done       (i_load_done),
    .o_load_full       (o_load_full),
    .o_write_count     (o_write_count),
    .o_overrun         (o_overrun),
    .i_swap_req        (i_swap_req),
    .o_swap_ack        (o_swap_ack),
    .o_read_bank       (o_read_bank),
    .o_read_bank_ready (o_read_bank_ready),
    .i_read_enable     (i_read_enable),
    .i_read_addr       (i_read_addr),
    .o_read_data       (o_read_data),
    .o_read_valid      (o_read_valid),
    .o_parity_err      (o_parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Element for load generation tag, filter f, address a, dot d
  function automatic logic [7:0] pat(input int tag, input int f, input int a, input int d);
    return 8'(tag*64 + f*16 + a*4 + d);
  endfunction

  function automatic logic [31:0] word(input int tag, input int f, input int a);
    logic [31:0] w;
    for (int d = 0; d < 4; d++) w[d*8 +: 8] = pat(tag, f, a, d);
    return w;
  endfunction

  function automatic logic [127:0] exp_read(input int tag, input int a);
    logic [127:0] r;
    for (int d = 0; d < 4; d++)
      for (int f = 0; f < 4; f++)
        r[(d*4+f)*8 +: 8] = pat(tag, f, a, d);
    return r;
  endfunction

  task automatic wr(input int pe, input int f, input int a, input logic [31:0] data);
    i_wr_enable    = 1'b1;
    i_wr_pe_id     = 4'(pe);
    i_wr_filter_id = 2'(f);
    i_wr_addr      = 9'(a);
    i_wr_data      = data;
    step();
    i_wr_enable    = 1'b0;
  endtask

  task automatic load_all(input int tag);
    for (int f = 0; f < 4; f++)
      for (int a = 0; a < 4; a++)
        wr(0, f, a, word(tag, f, a));
  endtask

  task automatic pulse_load_done();
    i_load_done = 1'b1;
    step();
    i_load_done = 1'b0;
  endtask

  task automatic read_expect(input string tag, input int a, input logic [127:0] exp,
                             input bit chk_data, input logic exp_perr);
    i_read_enable = 1'b1;
    i_read_addr   = 9'(a);
    step();
    i_read_enable = 1'b0;
    check({tag, "_lat1"}, o_read_valid, 1'b0);
    step();
    check({tag, "_valid"}, o_read_valid, 1'b1);
    if (chk_data) check({tag, "_data"}, o_read_data, exp);
    check({tag, "_perr"}, o_parity_err, exp_perr);
  endtask

  initial begin
    resetn = 1'b0; i_wr_enable = 1'b0; i_wr_pe_id = '0; i_wr_filter_id = '0;
    i_wr_addr = '0; i_wr_data = '0; i_load_done = 1'b0; i_swap_req = 1'b0;
    i_read_enable = 1'b0; i_read_addr = '0;
    #12;
    check("rst_bank", o_read_bank, 1'b0);
    check("rst_ready", o_read_bank_ready, 1'b0);
    check("rst_full", o_load_full, 1'b0);
    check("rst_count", o_write_count, 12'd0);
    check("rst_valid", o_read_valid, 1'b0);
    check("rst_data", o_read_data, 128'd0);
    check("rst_ack", o_swap_ack, 1'b0);
    check("rst_ovr", o_overrun, 1'b0);
    resetn = 1'b1;
    step();

    // First load into bank 1, then swap
    load_all(0);
    check("ld0_count", o_write_count, 12'd16);
    check("ld0_notfull", o_load_full, 1'b0);
    pulse_load_done();
    check("ld0_full", o_load_full, 1'b1);
    i_swap_req = 1'b1;
    step();
    check("sw0_ack", o_swap_ack, 1'b1);
    check("sw0_bank", o_read_bank, 1'b1);
    check("sw0_ready", o_read_bank_ready, 1'b1);
    check("sw0_count", o_write_count, 12'd0);
    check("sw0_full", o_load_full, 1'b0);
    i_swap_req = 1'b0;
    step();
    check("sw0_ack_pulse", o_swap_ack, 1'b0);

    // Single read, then back-to-back reads
    read_expect("rd2", 2, exp_read(0, 2), 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      i_read_enable = (c < 4);
      i_read_addr   = 9'(c);
      step();
      if (c >= 1 && c <= 4) begin
        check("b2b_valid", o_read_valid, 1'b1);
        check("b2b_data", o_read_data, exp_read(0, c - 1));
      end else begin
        check("b2b_idle", o_read_valid, 1'b0);
      end
    end
    i_read_enable = 1'b0;
    check("hold_data", o_read_data, exp_read(0, 3));

    // Ignored write, then overrun on a FULL load bank
    wr(1, 0, 0, 32'hFFFF_FFFF);
    check("ign_count", o_write_count, 12'd0);
    check("ign_ovr", o_overrun, 1'b0);
    load_all(1);
    pulse_load_done();
    check("ld1_full", o_load_full, 1'b1);
    wr(0, 0, 0, 32'hFFFF_FFFF);
    check("ovr_pulse", o_overrun, 1'b1);
    step();
    check("ovr_clear", o_overrun, 1'b0);
    check("ovr_count", o_write_count, 12'd16);
    i_swap_req = 1'b1;
    step();
    check("sw1_ack", o_swap_ack, 1'b1);
    check("sw1_bank", o_read_bank, 1'b0);
    i_swap_req = 1'b0;
    step();
    read_expect("ovr_rd", 0, exp_read(1, 0), 1'b1, 1'b0);

    // Swap request held while still loading
    load_all(2);
    check("ld2_count", o_write_count, 12'd16);
    i_swap_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("wait_noack", o_swap_ack, 1'b0);
    end
    i_load_done = 1'b1;
    step();
    i_load_done = 1'b0;
    check("done_noack", o_swap_ack, 1'b0);
    check("done_full", o_load_full, 1'b1);
    step();
    check("late_ack", o_swap_ack, 1'b1);
    check("late_bank", o_read_bank, 1'b1);
    // Read issued in the ack cycle returns old-bank data
    i_swap_req    = 1'b0;
    i_read_enable = 1'b1;
    i_read_addr   = 9'd3;
    step();
    i_read_enable = 1'b0;
    step();
    check("ackrd_valid", o_read_valid, 1'b1);
    check("ackrd_data", o_read_data, exp_read(1, 3));
    read_expect("newbank", 3, exp_read(2, 3), 1'b1, 1'b0);

    // Reset during a load with reads in flight
    wr(0, 0, 0, word(3, 0, 0));
    wr(0, 1, 0, word(3, 1, 0));
    check("ld3_count", o_write_count, 12'd2);
    i_read_enable = 1'b1;
    i_read_addr   = 9'd0;
    step();
    i_read_addr   = 9'd1;
    step();
    check("inflight_valid", o_read_valid, 1'b1);
    #1 resetn = 1'b0;
    #1;
    i_read_enable = 1'b0;
    check("mrst_valid", o_read_valid, 1'b0);
    check("mrst_bank", o_read_bank, 1'b0);
    check("mrst_ready", o_read_bank_ready, 1'b0);
    check("mrst_full", o_load_full, 1'b0);
    check("mrst_count", o_write_count, 12'd0);
    #2 resetn = 1'b1;
    step();
    check("mrst_discard0", o_read_valid, 1'b0);
    step();
    check("mrst_discard1", o_read_valid, 1'b0);

    // Zero-length load; bank 1 still holds the earlier load
    pulse_load_done();
    check("zl_full", o_load_full, 1'b1);
    check("zl_count", o_write_count, 12'd0);
    i_swap_req = 1'b1;
    step();
    check("zl_ack", o_swap_ack, 1'b1);
    check("zl_bank", o_read_bank, 1'b1);
    i_swap_req = 1'b0;
    step();
    read_expect("zl_rd", 0, exp_read(2, 0), 1'b1, 1'b0);

`ifdef PE_FILTER_CACHE_PARITY_EN
    dut.mem[1][2][0][0] = ~dut.mem[1][2][0][0];
    read_expect("par_bad", 0, 128'd0, 1'b0, 1'b1);
    read_expect("par_clean", 1, exp_read(2, 1), 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_filter_cache_pp.md
Name: pe_filter_cache_pp

Overview:
Per-PE filter cache: next generation of the single-bank PE filter RAM. Ping-pong double buffer: the sequencer loads one bank while the PE array reads the other. The swap is an explicit request/acknowledge handshake. Each filter has its own memory. Read data is dot-major across all filters and comes with a pipelined valid. The block sits between the filter-load broadcast bus and one PE's dot-product lanes.

Parameters:
PE_ID, 0, write-bus PE id this instance accepts
PE_ID_WIDTH, 4, width of the write-bus PE id
NUM_FILTERS, 4, filters (independent RAMs per bank)
NUM_DOTS, 4, dot lanes per filter word
ELEM_WIDTH, 8, bits per dot element
RAM_DEPTH, 512, words per filter per bank
ADDR_WIDTH, $clog2(RAM_DEPTH), word address width
FID_WIDTH, $clog2(NUM_FILTERS) (min 1), filter id width

Ports:
clock  in  1  sole clock, rising edge
resetn  in  1  asynchronous active-low reset
i_wr_enable  in  1  write request valid
i_wr_pe_id  in  PE_ID_WIDTH  target PE
i_wr_filter_id  in  FID_WIDTH  target filter
i_wr_addr  in  ADDR_WIDTH  word address
i_wr_data  in  NUM_DOTS*ELEM_WIDTH  dot d at [d*ELEM_WIDTH +: ELEM_WIDTH]
i_load_done  in  1  pulse: current load bank is complete
o_load_full  out  1  load bank is FULL
o_write_count  out  ADDR_WIDTH+FID_WIDTH+1  writes accepted into the load bank since it was last EMPTY
o_overrun  out  1  1-cycle pulse: matching write dropped
i_swap_req  in  1  level request to swap banks
o_swap_ack  out  1  1-cycle pulse: swap performed
o_read_bank  out  1  index of the current read bank
o_read_bank_ready  out  1  read bank holds a completed load
i_read_enable  in  1  read request
i_read_addr  in  ADDR_WIDTH  read word address
o_read_data  out  NUM_DOTS*NUM_FILTERS*ELEM_WIDTH  dot d of filter f at [(d*NUM_FILTERS+f)*ELEM_WIDTH +: ELEM_WIDTH]
o_read_valid  out  1  o_read_data valid
o_parity_err  out  1  parity error on a valid read (optional feature)

Behaviour:
- Reset values: o_read_bank=0 (load bank=1), load state EMPTY, o_write_count=0, o_read_bank_ready=0. All pulse outputs, o_load_full and o_read_valid are 0. o_read_data is 0 until the first valid read. RAM contents are not cleared.
- Storage: 2 banks x NUM_FILTERS x RAM_DEPTH x (NUM_DOTS*ELEM_WIDTH). Inferred simple dual-port memory with registered read address and registered output.
- Write acceptance: i_wr_enable && i_wr_pe_id==PE_ID && i_wr_filter_id<NUM_FILTERS.
  - Ids >= NUM_FILTERS and non-matching PE ids are ignored silently.
  - An accepted write goes to the load bank unless the load state is FULL. In that case the write is dropped and o_overrun pulses the next cycle.
- Load FSM (load bank):
  - EMPTY -> LOADING on the first accepted write.
  - EMPTY/LOADING -> FULL on i_load_done. A zero-length load is legal.
  - FULL -> EMPTY on swap.
  - A write and i_load_done in the same cycle: the write lands, then FULL.
  - i_load_done while FULL is ignored.
- o_write_count increments per accepted write. It saturates at all-ones and clears on swap.
- Swap: granted in a cycle where i_swap_req=1 and the registered state is FULL.
  - Next edge: o_read_bank toggles, o_swap_ack pulses for 1 cycle, o_read_bank_ready=1, new load bank = EMPTY.
  - i_swap_req held with load not FULL waits. i_load_done in the request cycle delays the grant by 1 cycle.
- Read:
  - Latency 2. i_read_enable in cycle N gives o_read_valid plus data in cycle N+2. Throughput 1 per cycle.
  - Bank select is captured with the address and pipelined. A read issued in the ack cycle or earlier returns old-bank data even if it completes after the swap.
  - With i_read_enable=0, o_read_data holds its last value.
- Reads while o_read_bank_ready=0 are performed and flagged valid. Data is undefined and the bench must not check it.
- Read and write never target the same bank, so there is no collision case.
- Async reset mid-operation clears the FSM, the pipeline valids and the counters immediately. In-flight reads are discarded.

Optional Feature:
PE_FILTER_CACHE_PARITY_EN:
- Defined: each filter word stores one extra even-parity bit computed on write. On the read output stage, a mismatch in any filter raises o_parity_err in the same cycle as o_read_valid.
- Undefined: no parity storage, and o_parity_err is tied 0.

Test Plan:
- Reset, then load filters 0..3 addr 0..3 with data {f,a} pattern, i_load_done, i_swap_req -> o_swap_ack 1 cycle after FULL, o_read_bank=1, o_read_bank_ready=1, o_write_count=0.
- Read addr 2 at cycle N -> o_read_valid at N+2, lane (d,f) = load pattern for filter f, addr 2, dot d. Back-to-back reads addr 0..3 return 4 consecutive valids.
- Load bank FULL, write matching PE -> dropped, o_overrun pulse, bank contents unchanged on the later swap-and-read. Writes with pe_id!=PE_ID or filter_id=NUM_FILTERS -> no effect, no overrun.
- i_swap_req held with load bank LOADING for 10 cycles -> no ack. i_load_done -> ack 2 cycles later. A read issued in the ack cycle returns old-bank data.
- Assert resetn low during load and with reads in flight -> o_read_valid drops immediately, FSM EMPTY, o_read_bank=0, o_read_bank_ready=0.
- With PE_FILTER_CACHE_PARITY_EN: force a flipped stored bit via the bench's memory-backdoor write -> o_parity_err=1 with that read's o_read_valid. Clean reads -> 0.
